// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer arbiter bus: scan-out read port, drawing-engine port and the
// single-port RAM command/response port, bundled for the arbiter.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 24
);
   logic              scanReq;
   logic [ADDR_W-1:0] scanAddr;
   logic              scanValid;
   logic [DATA_W-1:0] scanData;

   logic              drawReq;
   logic              drawWe;
   logic [ADDR_W-1:0] drawAddr;
   logic [DATA_W-1:0] drawWData;
   logic              drawAck;
   logic              drawRValid;
   logic [DATA_W-1:0] drawRData;

   logic              memEn;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWData;
   logic [DATA_W-1:0] memRData;

   // arbiter side
   modport slave (
      input  scanReq, scanAddr, drawReq, drawWe, drawAddr, drawWData, memRData,
      output scanValid, scanData, drawAck, drawRValid, drawRData,
             memEn, memWe, memAddr, memWData
   );

   // requesters plus RAM side
   modport master (
      output scanReq, scanAddr, drawReq, drawWe, drawAddr, drawWData, memRData,
      input  scanValid, scanData, drawAck, drawRValid, drawRData,
             memEn, memWe, memAddr, memWData
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port framebuffer RAM between VGA scan-out
// reads (absolute priority, fixed 3-cycle latency) and the drawing engine
// (writes posted through a 1-entry buffer, reads in otherwise free slots).
//
// Draw FSM
//   state  | meaning
//   D_IDLE | no draw read outstanding; draw reads and writes may be accepted
//   D_RD   | a draw read is in the pipeline; new reads wait for its drawRValid
module vga_fb_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 24
) (
   input  logic            clkDiv,
   input  logic            rst,
   vga_fb_arbiter_if.slave bus
);

   typedef enum logic {
      D_IDLE = 1'b0,
      D_RD   = 1'b1
   } draw_state_t;

   draw_state_t       r_state;
   draw_state_t       w_stateNxt;

   logic              r_wbValid;
   logic [ADDR_W-1:0] r_wbAddr;
   logic [DATA_W-1:0] r_wbData;
   logic              r_drawAck;

   logic              r_memEn;
   logic              r_memWe;
   logic [ADDR_W-1:0] r_memAddr;
   logic [DATA_W-1:0] r_memWData;

   logic              r_s1Scan;
   logic              r_s1Rd;
   logic              r_s1Fwd;
   logic [DATA_W-1:0] r_s1FwdData;
   logic              r_s2Scan;
   logic              r_s2Rd;
   logic              r_s2Fwd;
   logic [DATA_W-1:0] r_s2FwdData;

   logic              r_scanValid;
   logic [DATA_W-1:0] r_scanData;
   logic              r_drawRValid;
   logic [DATA_W-1:0] r_drawRData;

   logic              w_drain;
   logic              w_fwdHit;
   logic              w_wrAcc;
   logic              w_rdAcc;
   logic              w_rdSlot;

   // Slot decision, draw acceptance and FSM next state for this edge
   always_comb begin
      w_stateNxt = r_state;
      w_drain    = 1'b0;
      w_fwdHit   = 1'b0;
      w_wrAcc    = 1'b0;
      w_rdAcc    = 1'b0;
      w_rdSlot   = 1'b0;

      // scan-out owns the slot whenever it asks; the buffer drains otherwise
      w_drain  = r_wbValid && !bus.scanReq;
      w_fwdHit = r_wbValid && (bus.drawAddr == r_wbAddr);

      // a write may reload the buffer on the same edge it drains
      w_wrAcc = bus.drawReq && bus.drawWe && !r_drawAck && (!r_wbValid || w_drain);

      // forwarded reads bypass the RAM, so they ignore slot priority
      w_rdAcc = bus.drawReq && !bus.drawWe && !r_drawAck && (r_state == D_IDLE) &&
                (w_fwdHit || (!bus.scanReq && !r_wbValid));
      w_rdSlot = w_rdAcc && !w_fwdHit;

      case (r_state)
         D_IDLE:  if (w_rdAcc)      w_stateNxt = D_RD;
         D_RD:    if (r_drawRValid) w_stateNxt = D_IDLE;
         default: w_stateNxt = D_IDLE;
      endcase
   end

   // Draw FSM state register
   always_ff @(posedge clkDiv or negedge rst) begin
      if (!rst) r_state <= D_IDLE;
      else      r_state <= w_stateNxt;
   end

   // Posted write buffer and the draw acceptance pulse
   always_ff @(posedge clkDiv or negedge rst) begin
      if (!rst) begin
         r_wbValid <= 1'b0;
         r_wbAddr  <= '0;
         r_wbData  <= '0;
         r_drawAck <= 1'b0;
      end else begin
         r_drawAck <= w_wrAcc || w_rdAcc;
         if (w_wrAcc) begin
            r_wbValid <= 1'b1;
            r_wbAddr  <= bus.drawAddr;
            r_wbData  <= bus.drawWData;
         end else if (w_drain) begin
            r_wbValid <= 1'b0;
         end
      end
   end

   // RAM command register; an idle slot drops memEn and holds the rest
   always_ff @(posedge clkDiv or negedge rst) begin
      if (!rst) begin
         r_memEn    <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWData <= '0;
      end else if (bus.scanReq) begin
         r_memEn   <= 1'b1;
         r_memWe   <= 1'b0;
         r_memAddr <= bus.scanAddr;
      end else if (w_drain) begin
         r_memEn    <= 1'b1;
         r_memWe    <= 1'b1;
         r_memAddr  <= r_wbAddr;
         r_memWData <= r_wbData;
      end else if (w_rdSlot) begin
         r_memEn   <= 1'b1;
         r_memWe   <= 1'b0;
         r_memAddr <= bus.drawAddr;
      end else begin
         r_memEn <= 1'b0;
      end
   end

   // Read tags travel alongside the RAM access so every read lands at E+3
   always_ff @(posedge clkDiv or negedge rst) begin
      if (!rst) begin
         r_s1Scan    <= 1'b0;
         r_s1Rd      <= 1'b0;
         r_s1Fwd     <= 1'b0;
         r_s1FwdData <= '0;
         r_s2Scan    <= 1'b0;
         r_s2Rd      <= 1'b0;
         r_s2Fwd     <= 1'b0;
         r_s2FwdData <= '0;
      end else begin
         r_s1Scan <= bus.scanReq;
         r_s1Rd   <= w_rdAcc;
         r_s1Fwd  <= w_rdAcc && w_fwdHit;
         if (w_rdAcc && w_fwdHit) r_s1FwdData <= r_wbData;
         r_s2Scan    <= r_s1Scan;
         r_s2Rd      <= r_s1Rd;
         r_s2Fwd     <= r_s1Fwd;
         r_s2FwdData <= r_s1FwdData;
      end
   end

   // Response registers: capture RAM data (or the forwarded snapshot)
   always_ff @(posedge clkDiv or negedge rst) begin
      if (!rst) begin
         r_scanValid  <= 1'b0;
         r_scanData   <= '0;
         r_drawRValid <= 1'b0;
         r_drawRData  <= '0;
      end else begin
         r_scanValid  <= r_s2Scan;
         r_drawRValid <= r_s2Rd;
         if (r_s2Scan) r_scanData <= bus.memRData;
         if (r_s2Rd)   r_drawRData <= r_s2Fwd ? r_s2FwdData : bus.memRData;
      end
   end

   assign bus.scanValid  = r_scanValid;
   assign bus.scanData   = r_scanData;
   assign bus.drawAck    = r_drawAck;
   assign bus.drawRValid = r_drawRValid;
   assign bus.drawRData  = r_drawRData;
   assign bus.memEn      = r_memEn;
   assign bus.memWe      = r_memWe;
   assign bus.memAddr    = r_memAddr;
   assign bus.memWData   = r_memWData;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model (framebuffer contents as seen by
// the drawing engine, fixed 3-cycle read latency, one drain per write).
module tb_vga_fb_arbiter;
   localparam int AW = 16;
   localparam int DW = 24;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } exp_t;

   logic clkDiv = 1'b0;
   logic rst    = 1'b0;
   always #20 clkDiv = ~clkDiv;

   vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clkDiv (clkDiv),
      .rst    (rst),
      .bus    (bus)
   );

   // RAM contents: never-written words return a fixed per-address pattern
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 16'h0000) return 24'h123456;
      if (a == 16'h0001) return 24'hABCDEF;
      return {a[7:0] ^ 8'h5A, a[15:8], ~a[7:0]};
   endfunction

   logic [DW-1:0] ram    [0:65535];
   bit            ram_wr [0:65535];

   // synchronous single-port RAM, 1-cycle read latency
   always @(posedge clkDiv) begin
      if (bus.memEn) begin
         if (bus.memWe) begin
            ram[bus.memAddr]    <= bus.memWData;
            ram_wr[bus.memAddr] <= 1'b1;
         end else begin
            bus.memRData <= ram_wr[bus.memAddr] ? ram[bus.memAddr] : init_val(bus.memAddr);
         end
      end
   end

   function automatic logic [DW-1:0] ram_peek(input logic [AW-1:0] a);
      return ram_wr[a] ? ram[a] : init_val(a);
   endfunction

   // reference view of the framebuffer: latest accepted write per address
   logic [DW-1:0] ref_mem [int];

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_val(a);
   endfunction

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   exp_t sq[$];
   exp_t dq[$];
   int wr_pulses = 0, wr_acks = 0, en_cnt = 0;
   int last_rv_cyc = -1, last_wr_cmd_cyc = -1;
   logic [AW-1:0] last_wr_cmd_addr = '0;
   int probe_addr = -1, probe_rd = 0;
   int scan_left = 0;
   logic [AW-1:0] scan_next = '0;
   bit scan_rand = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (!rst) begin
         sq.delete();
         dq.delete();
         return;
      end
      if (sq.size() > 0 && sq[0].due == cyc) begin
         chk("scan_valid", 32'(bus.scanValid), 1);
         chk("scan_data", 32'(bus.scanData), 32'(sq[0].data));
         void'(sq.pop_front());
      end else begin
         chk("scan_quiet", 32'(bus.scanValid), 0);
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
         chk("rd_valid", 32'(bus.drawRValid), 1);
         chk("rd_data", 32'(bus.drawRData), 32'(dq[0].data));
         last_rv_cyc = cyc;
         void'(dq.pop_front());
      end else begin
         chk("rd_quiet", 32'(bus.drawRValid), 0);
      end
      if (bus.memEn) en_cnt++;
      if (bus.memEn && bus.memWe) begin
         wr_pulses++;
         last_wr_cmd_cyc  = cyc;
         last_wr_cmd_addr = bus.memAddr;
      end
      if (bus.memEn && !bus.memWe && int'(bus.memAddr) == probe_addr) probe_rd++;
      if (bus.drawAck) begin
         if (bus.drawWe) begin
            ref_mem[int'(bus.drawAddr)] = bus.drawWData;
            wr_acks++;
         end else begin
            chk("rd_overlap", 32'(dq.size()), 0);
            e.due  = cyc + 2;
            e.data = ref_rd(bus.drawAddr);
            dq.push_back(e);
         end
      end
   endtask

   task automatic drive_scan();
      exp_t e;
      logic [AW-1:0] a;
      bit go;
      go = 1'b0;
      if (scan_left > 0) begin
         go = 1'b1;
         a  = scan_next;
         scan_next = scan_next + 16'd1;
         scan_left--;
      end else if (scan_rand && $urandom_range(0, 99) < 40) begin
         go = 1'b1;
         a  = 16'h0100 + 16'($urandom_range(0, 15));
      end
      if (go && rst) begin
         bus.scanReq  = 1'b1;
         bus.scanAddr = a;
         e.due  = cyc + 3;
         e.data = ref_rd(a);
         sq.push_back(e);
      end else begin
         bus.scanReq = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clkDiv);
      #1;
      cyc++;
      monitor();
      drive_scan();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic draw_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int ack_cyc);
      int n;
      n = 0;
      bus.drawReq   = 1'b1;
      bus.drawWe    = we;
      bus.drawAddr  = a;
      bus.drawWData = d;
      do begin
         tick();
         n++;
      end while (!bus.drawAck && n < 300);
      chk("draw_ack", 32'(bus.drawAck), 1);
      ack_cyc = cyc;
      bus.drawReq = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_scanValid"},  32'(bus.scanValid), 0);
      chk({tag, "_drawAck"},    32'(bus.drawAck), 0);
      chk({tag, "_drawRValid"}, 32'(bus.drawRValid), 0);
      chk({tag, "_memEn"},      32'(bus.memEn), 0);
      chk({tag, "_memWe"},      32'(bus.memWe), 0);
      chk({tag, "_scanData"},   32'(bus.scanData), 0);
      chk({tag, "_drawRData"},  32'(bus.drawRData), 0);
      chk({tag, "_memAddr"},    32'(bus.memAddr), 0);
      chk({tag, "_memWData"},   32'(bus.memWData), 0);
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, c1, c2, w0, k0;
      bus.scanReq   = 1'b0;
      bus.scanAddr  = '0;
      bus.drawReq   = 1'b0;
      bus.drawWe    = 1'b0;
      bus.drawAddr  = '0;
      bus.drawWData = '0;
      rst = 1'b0;
      idle(3);
      chk_outputs_zero("reset");
      rst = 1'b1;

      // scan only: two consecutive scan reads of preloaded words 0 and 1
      scan_next = 16'h0000;
      scan_left = 2;
      en_cnt    = 0;
      idle(8);
      chk("scan_en_cnt", 32'(en_cnt), 2);

      // write then read of the same word; scans keep the buffer occupied
      // so the read is served from the write buffer
      scan_next  = 16'h0100;
      scan_left  = 6;
      probe_addr = 16'h0010;
      probe_rd   = 0;
      tick();
      draw_txn(1'b1, 16'h0010, 24'h00F0F0, a1);
      draw_txn(1'b0, 16'h0010, 24'h000000, c1);
      idle(10);
      chk("fwd_no_ram_rd", 32'(probe_rd), 0);
      chk("fwd_drained", 32'(ram_peek(16'h0010)), 32'(ref_rd(16'h0010)));
      probe_addr = -1;

      // contention: scan held 8 edges, buffered write and a pending read
      scan_next = 16'h0100;
      scan_left = 8;
      tick();
      draw_txn(1'b1, 16'h0028, 24'h2468AC, a1);
      draw_txn(1'b0, 16'h0020, 24'h000000, c1);
      chk("cont_drain_cyc", 32'(last_wr_cmd_cyc), 32'(a1 + 8));
      chk("cont_drain_addr", 32'(last_wr_cmd_addr), 32'h28);
      chk("cont_rd_ack", 32'(c1), 32'(a1 + 9));
      idle(6);

      // back-to-back writes with no scan traffic
      w0 = wr_pulses;
      draw_txn(1'b1, 16'h0030, 24'h303030, a1);
      draw_txn(1'b1, 16'h0031, 24'h313131, a2);
      idle(4);
      chk("b2b_gap", 32'(a2 - a1), 2);
      chk("b2b_wr_pulses", 32'(wr_pulses - w0), 2);
      chk("b2b_ram30", 32'(ram_peek(16'h0030)), 32'(ref_rd(16'h0030)));
      chk("b2b_ram31", 32'(ram_peek(16'h0031)), 32'(ref_rd(16'h0031)));

      // a read in flight blocks the next read until its data returns
      draw_txn(1'b0, 16'h0040, 24'h000000, c1);
      draw_txn(1'b0, 16'h0041, 24'h000000, c2);
      chk("rd_block", 32'((c2 > last_rv_cyc) && (last_rv_cyc > c1)), 1);
      idle(5);

      // reset right after a forwarded read is accepted, buffer still full
      scan_next = 16'h0100;
      scan_left = 6;
      tick();
      draw_txn(1'b1, 16'h0050, 24'h777777, a1);
      draw_txn(1'b0, 16'h0050, 24'h000000, c1);
      rst = 1'b0;
      scan_left   = 0;
      bus.scanReq = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      idle(2);
      rst = 1'b1;
      ref_mem.delete(int'(16'h0050));
      idle(8);
      chk("rst_wb_lost", 32'(ram_peek(16'h0050)), 32'(ref_rd(16'h0050)));

      // randomized traffic: scans on a separate region, draw ops on 8 words
      w0 = wr_pulses;
      k0 = wr_acks;
      scan_rand = 1'b1;
      for (int i = 0; i < 250; i++) begin
         logic          we;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         int            ac;
         idle($urandom_range(0, 2));
         we = 1'($urandom_range(0, 1));
         a  = 16'h0200 + 16'($urandom_range(0, 7));
         d  = 24'($urandom);
         draw_txn(we, a, d, ac);
      end
      scan_rand = 1'b0;
      idle(10);
      chk("rand_wr_pulses", 32'(wr_pulses - w0), 32'(wr_acks - k0));
      for (int i = 0; i < 8; i++) begin
         logic [AW-1:0] a;
         a = 16'h0200 + 16'(i);
         chk("rand_ram", 32'(ram_peek(a)), 32'(ref_rd(a)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares the single-port framebuffer RAM between the VGA scan-out fetcher and the drawing engine, on the pixel clock domain (clkDiv, 25 MHz). Each request is 24 bits: a word of 8 pixels, 3 bits per pixel (R,G,B). Scan-out reads have absolute priority and a fixed latency, so the display never under-runs. Drawing-engine writes are posted through a 1-entry buffer. Drawing-engine reads use slots that scan-out and drain traffic leave free.

## Interface
- ADDR_W, 16, word address width (80 words/line × 480 lines = 38400 words)
- DATA_W, 24, word width (8 pixels × RGB)

- clkDiv  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset rst, asynchronous, active-low
- scanReq  in  1  scan-out read request, one cycle per word
- scanAddr  in  ADDR_W  scan word address, valid with scanReq
- scanValid  out  1  scan data valid pulse
- scanData  out  DATA_W  scan read data
- drawReq  in  1  draw request, held until drawAck
- drawWe  in  1  1 = write, 0 = read; stable while drawReq=1
- drawAddr  in  ADDR_W  draw address; stable while drawReq=1
- drawWData  in  DATA_W  draw write data; stable while drawReq=1
- drawAck  out  1  one-cycle acceptance pulse
- drawRValid  out  1  draw read data valid pulse
- drawRData  out  DATA_W  draw read data
- memEn, memWe  out  1  RAM command; synchronous read, 1-cycle latency
- memAddr  out  ADDR_W  RAM address
- memWData  out  DATA_W  RAM write data
- memRData  in  DATA_W  RAM read data, valid the cycle after a read command

## Operation
- Memory slot is decided at each edge. Priority: (1) scanReq, (2) drain of the write buffer (wbValid), (3) draw read that is not forwarded.
- Accepting a draw write: drawReq=1, drawWe=1, drawAck low this cycle, and either wbValid=0 or the buffer is draining this edge. The request loads wbAddr/wbData, sets wbValid, and pulses drawAck. Acceptance does not depend on scanReq.
- Accepting a draw read: drawReq=1, drawWe=0, drawAck low, and no draw read in flight.
  - If wbValid=1 and drawAddr==wbAddr: the read is forwarded from wbData with no RAM access, and it ignores slot priority.
  - Otherwise the read needs the slot: scanReq=0 and wbValid=0.
- drawReq is ignored in any cycle in which drawAck is high. The requester presents its next transaction from the following edge. Maximum draw throughput is one transaction per 2 cycles.
- Draw FSM has two states:
  - D_IDLE → D_RD when a read is accepted.
  - D_RD → D_IDLE on the drawRValid pulse.
  - Writes never leave D_IDLE.
- If a write is accepted while a buffered write drains on the same edge, the buffer reloads with the new data and wbValid stays 1.
- A second write to an address that is still buffered waits until the drain completes. No merging.
- scanReq on consecutive cycles is legal and every request is served. Draw reads and drains stall for as long as scanReq is held.
- Address range is not checked. Addresses wrap at the ADDR_W boundary as issued.

## Timing
- Let E be the acceptance edge.
  - Memory command is registered and driven during cycle E+1.
  - memRData is captured at edge E+2.
  - scanValid/scanData (or drawRValid/drawRData) are registered and high during cycle E+3.
- Latency is fixed at 3 cycles for scan reads and for all draw reads, forwarded or not. Forwarded data is snapshotted at E and delayed through the same pipeline.
- drawAck is high during cycle E+1.
- A buffer drain issues memEn=1, memWe=1 during E+1 of its slot.
- When the slot is idle, memEn=0; memWe, memAddr and memWData hold their last values.
- Reset (asserted asynchronously, at any time):
  - Outputs: scanValid, drawAck, drawRValid, memEn and memWe are 0. scanData, drawRData, memAddr and memWData are 0.
  - State: wbValid=0, draw FSM in D_IDLE.
  - In-flight reads are dropped with no valid pulse. A buffered write is lost.
- After rst deasserts, the first request can be accepted at the first rising edge.

## Test plan
- Scan only: scanReq pulses at addr 0x0000 and 0x0001 on consecutive edges, with RAM preloaded 0x123456/0xABCDEF → scanValid at E+3 and E+4 with the data in order; memEn high 2 cycles.
- Write then read: write 0x00F0F0 @0x0010, then read @0x0010 issued on the next legal edge → read is forwarded (no memEn read), drawRData=0x00F0F0 at acceptance+3; RAM holds 0x00F0F0 once the buffer has drained.
- Contention: scanReq held 8 cycles while wbValid=1 and a draw read @0x0020 is pending → drain issues at the first edge with scanReq=0, the read issues on the edge after that, and no scanValid is missing or late.
- Back-to-back writes @0x0030 and @0x0031 with scanReq=0 → drawAck every 2nd cycle, two memWe pulses, wbValid=0 afterwards.
- Read in flight blocks: two reads @0x0040 and @0x0041 → second drawAck only after the first drawRValid.
- Reset mid-operation: rst low one cycle after a read is accepted and with wbValid=1 → all outputs are 0 immediately, no drawRValid appears, and after release RAM @ the buffered address is unchanged.
